// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX->MEM stage: exception codes, memory access
// sizes, stage state encoding and the registered stage payload.
package ex_mem_stage_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Size code 3 has no access of its own and is handled as a word.
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  typedef enum logic {
    RUN      = 1'b0,
    EXC_PEND = 1'b1
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [31:0] store_data;
    logic [31:0] result;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
  } stage_reg_t;

  function automatic logic addr_misaligned(input logic [1:0] addr,
                                           input logic [1:0] size);
    logic mis;
    case (size)
      MEM_B:   mis = 1'b0;
      MEM_H:   mis = addr[0];
      default: mis = (addr != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Bundle between EX, hazard control and the EX->MEM stage, plus the MEM-side
// outputs and the forwarding source fed back to EX.
interface ex_mem_stage_if;

  // i_valid qualifies the whole EX bundle on the edge it is sampled. There is
  // no ready: back-pressure is i_stall, which freezes the stage, and i_flush
  // discards both the registered and the incoming instruction.
  logic        i_stall;
  logic        i_flush;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [4:0]  i_rd;
  logic        i_reg_write;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [1:0]  i_mem_size;
  logic [31:0] i_store_data;
  logic [31:0] i_alu_result;
  logic        i_alu_overflow;
  logic        i_alu_no_write_override;

  logic        o_valid;
  logic [31:0] o_pc;
  logic [4:0]  o_rd;
  logic        o_reg_write;
  logic        o_mem_read;
  logic        o_mem_write;
  logic [1:0]  o_mem_size;
  logic [31:0] o_store_data;
  logic [31:0] o_result;
  logic        o_exc_valid;
  logic [4:0]  o_exc_code;
  logic [31:0] o_exc_epc;
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_rd;
  logic [31:0] o_fwd_data;

  modport master (
    output i_stall, i_flush, i_valid, i_pc, i_rd, i_reg_write, i_mem_read,
           i_mem_write, i_mem_size, i_store_data, i_alu_result,
           i_alu_overflow, i_alu_no_write_override,
    input  o_valid, o_pc, o_rd, o_reg_write, o_mem_read, o_mem_write,
           o_mem_size, o_store_data, o_result, o_exc_valid, o_exc_code,
           o_exc_epc, o_fwd_valid, o_fwd_rd, o_fwd_data
  );

  modport slave (
    input  i_stall, i_flush, i_valid, i_pc, i_rd, i_reg_write, i_mem_read,
           i_mem_write, i_mem_size, i_store_data, i_alu_result,
           i_alu_overflow, i_alu_no_write_override,
    output o_valid, o_pc, o_rd, o_reg_write, o_mem_read, o_mem_write,
           o_mem_size, o_store_data, o_result, o_exc_valid, o_exc_code,
           o_exc_epc, o_fwd_valid, o_fwd_rd, o_fwd_data
  );

endinterface

// File: rtl/mem_align_check.sv
// Load/store address alignment check; yields AdEL for loads, AdES for stores.
module mem_align_check
  import ex_mem_stage_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic [1:0] addr,
  input  logic [1:0] size,
  input  logic       rd,
  input  logic       wr,
  output logic       mis,
  output logic [4:0] code
);

  always_comb begin
    mis  = ALIGN_CHECK && (rd || wr) && addr_misaligned(addr, size);
    code = EXC_NONE;
    if (mis) begin
      code = rd ? EXC_ADEL : EXC_ADES;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: turns overflow and misaligned accesses into
// precise exceptions, gates GPR/memory writes and sources EX forwarding.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  ex_mem_stage_if.slave  bus,
  output state_t         o_state
);

  state_t     state_q, state_nxt;
  stage_reg_t reg_q, reg_nxt;

  logic       mis;
  logic [4:0] align_code;
  logic       exc;
  logic [4:0] exc_code;

  mem_align_check #(
    .ALIGN_CHECK(ALIGN_CHECK)
  ) u_align (
    .addr (bus.i_alu_result[1:0]),
    .size (bus.i_mem_size),
    .rd   (bus.i_mem_read),
    .wr   (bus.i_mem_write),
    .mis  (mis),
    .code (align_code)
  );

  // Overflow outranks any alignment fault on the same instruction.
  always_comb begin
    exc      = bus.i_alu_overflow | mis;
    exc_code = bus.i_alu_overflow ? EXC_OV : align_code;
  end

  always_comb begin
    state_nxt = state_q;
    reg_nxt   = reg_q;
    if (bus.i_flush) begin
      reg_nxt   = '0;
      state_nxt = RUN;
    end else if (!bus.i_stall) begin
      // Anything not accepted below leaves a fully cleared bubble.
      reg_nxt = '0;
      if (state_q == RUN && bus.i_valid) begin
        reg_nxt.valid      = 1'b1;
        reg_nxt.pc         = bus.i_pc;
        reg_nxt.rd         = bus.i_rd;
        reg_nxt.mem_size   = bus.i_mem_size;
        reg_nxt.store_data = bus.i_store_data;
        reg_nxt.result     = bus.i_alu_result;
        reg_nxt.reg_write  = bus.i_reg_write & bus.i_alu_no_write_override
                             & ~exc & (bus.i_rd != 5'd0);
        reg_nxt.mem_read   = bus.i_mem_read & ~exc;
        reg_nxt.mem_write  = bus.i_mem_write & ~exc;
        if (exc) begin
          reg_nxt.exc_valid = 1'b1;
          reg_nxt.exc_code  = exc_code;
          reg_nxt.exc_epc   = bus.i_pc;
          state_nxt         = EXC_PEND;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      reg_q <= '0;
    end else begin
      reg_q <= reg_nxt;
    end
  end

  assign o_state          = state_q;
  assign bus.o_valid      = reg_q.valid;
  assign bus.o_pc         = reg_q.pc;
  assign bus.o_rd         = reg_q.rd;
  assign bus.o_reg_write  = reg_q.reg_write;
  assign bus.o_mem_read   = reg_q.mem_read;
  assign bus.o_mem_write  = reg_q.mem_write;
  assign bus.o_mem_size   = reg_q.mem_size;
  assign bus.o_store_data = reg_q.store_data;
  assign bus.o_result     = reg_q.result;
  assign bus.o_exc_valid  = reg_q.exc_valid;
  assign bus.o_exc_code   = reg_q.exc_code;
  assign bus.o_exc_epc    = reg_q.exc_epc;

  // A load's result is an address, not the value headed for rd.
  assign bus.o_fwd_valid  = reg_q.valid & reg_q.reg_write & ~reg_q.mem_read;
  assign bus.o_fwd_rd     = reg_q.rd;
  assign bus.o_fwd_data   = reg_q.result;

endmodule
